// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: redirect input, IDU valid/ready output stream, AXI4-Lite read channels.
interface ifu_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_ins;
  logic              out_err;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    input  redirect_valid, redirect_pc, out_ready, arready, rdata, rresp, rvalid,
    output out_valid, out_pc, out_ins, out_err, araddr, arvalid, rready
  );

  modport slave (
    output redirect_valid, redirect_pc, out_ready, arready, rdata, rresp, rvalid,
    input  out_valid, out_pc, out_ins, out_err, araddr, arvalid, rready
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Prefetching instruction fetch unit: single-outstanding AXI4-Lite read master feeding a
// DEPTH-entry queue toward the IDU, with redirect flush and fault halt.
module ifu_fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000),
  parameter int unsigned       DEPTH    = 2,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifu_fetch_if.master   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + DATA_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              halted_q, halted_d;
  logic              discard_q, discard_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              push_c;
  logic              pop_c;
  logic              not_empty_c;
  logic              has_space_c;
  logic [ENT_W-1:0]  push_entry_c;
  logic [ENT_W-1:0]  head_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty_c  = (count_q != '0);
  assign has_space_c  = (count_q < CNT_W'(DEPTH));
  assign push_entry_c = {araddr_q, bus.rdata, (bus.rresp != 2'b00)};
  assign head_c       = mem_q[rd_ptr_q];

  // A redirect hides the head so its same-cycle pop never happens.
  assign bus.out_valid = not_empty_c & ~bus.redirect_valid;
  assign pop_c         = bus.out_valid & bus.out_ready;
  assign bus.out_pc    = head_c[ENT_W-1 -: ADDR_W];
  assign bus.out_ins   = head_c[DATA_W:1];
  assign bus.out_err   = head_c[0];
  assign bus.araddr    = araddr_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.rready    = rready_q;

  // Next-state logic for the read master and the queue bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    halted_d   = halted_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Hold off one cycle on a redirect so the AR carries the new target.
        if (!bus.redirect_valid && !halted_q && has_space_c) begin
          state_d   = S_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = fetch_pc_q;
        end
      end
      S_ADDR: begin
        if (arvalid_q && bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
        if (bus.redirect_valid) discard_d = 1'b1;
      end
      S_DATA: begin
        if (rready_q && bus.rvalid) begin
          rready_d  = 1'b0;
          discard_d = 1'b0;
          state_d   = S_IDLE;
          if (!discard_q && !bus.redirect_valid) begin
            push_c     = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            if (bus.rresp != 2'b00) halted_d = 1'b1;
          end
        end else if (bus.redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      halted_d   = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      halted_q   <= 1'b0;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      halted_q   <= halted_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset; count_q qualifies every read.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_entry_c;
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: AXI slave model, AR and IDU scoreboards, scripted corner cases.
module tb_ifu_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   del_cnt;
  int   r_delay;
  int   ar_stall;
  logic [31:0] err_addr;
  ent_t        img [3];
  ent_t        exp_out [$];
  logic [31:0] exp_ar [$];

  ifu_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifu_fetch_queue #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h8000_0000), .DEPTH(2), .PC_STEP(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    logic [31:0] r;
    r = a ^ 32'h5A5A_00FF;
    for (int i = 0; i < 3; i++) if (img[i].pc == a) r = img[i].ins;
    return r;
  endfunction

  function automatic ent_t mk(input logic [31:0] pc, input logic err);
    ent_t e;
    e.pc  = pc;
    e.ins = ins_of(pc);
    e.err = err;
    return e;
  endfunction

  // AXI read slave: accepts AR, answers after r_delay cycles, flags err_addr with SLVERR.
  initial begin
    logic pend, hs_ar, hs_r, hold;
    logic [31:0] paddr, hs_addr, last_addr;
    int wait_n;
    pend = 0; hs_ar = 0; hs_r = 0; hold = 0;
    paddr = 0; hs_addr = 0; last_addr = 0; wait_n = 0;
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (hs_r) pend = 0;
      if (hs_ar) begin
        pend   = 1;
        paddr  = hs_addr;
        wait_n = r_delay;
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ar: got araddr %h required no request", hs_addr);
        end else begin
          check32("araddr", hs_addr, exp_ar.pop_front());
        end
      end
      if (hold) begin
        check32("ar_hold_valid", 32'(bus.arvalid), 32'd1);
        check32("ar_hold_addr", bus.araddr, last_addr);
      end
      if (bus.arvalid === 1'b1 && ar_stall > 0) begin
        bus.arready = 1'b0;
        ar_stall--;
      end else begin
        bus.arready = 1'b1;
      end
      if (pend && wait_n > 0) begin
        bus.rvalid = 1'b0;
        wait_n--;
      end else begin
        bus.rvalid = pend;
      end
      bus.rdata = pend ? ins_of(paddr) : 32'h0;
      bus.rresp = (pend && paddr == err_addr) ? 2'b10 : 2'b00;
      hs_ar     = (bus.arvalid === 1'b1) && bus.arready && !rst;
      hs_addr   = bus.araddr;
      hs_r      = bus.rvalid && (bus.rready === 1'b1) && !rst;
      hold      = (bus.arvalid === 1'b1) && !bus.arready && !rst;
      last_addr = bus.araddr;
    end
  end

  // IDU side: scoreboard pops on each accepted head, and held heads must not change.
  initial begin
    logic hold_o;
    ent_t held, e;
    hold_o = 0;
    held = '{32'h0, 32'h0, 1'b0};
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0) begin
        if (hold_o && !bus.redirect_valid) begin
          check32("hold_valid", 32'(bus.out_valid), 32'd1);
          check32("hold_pc", bus.out_pc, held.pc);
          check32("hold_ins", bus.out_ins, held.ins);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready) begin
          del_cnt++;
          if (exp_out.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_delivery: got pc %h required no entry", bus.out_pc);
          end else begin
            e = exp_out.pop_front();
            check32("out_pc", bus.out_pc, e.pc);
            check32("out_ins", bus.out_ins, e.ins);
            check32("out_err", 32'(bus.out_err), 32'(e.err));
          end
        end
        hold_o   = (bus.out_valid === 1'b1) && !bus.out_ready;
        held.pc  = bus.out_pc;
        held.ins = bus.out_ins;
      end
    end
  end

  task automatic push_both(input logic [31:0] pc, input logic err);
    exp_ar.push_back(pc);
    exp_out.push_back(mk(pc, err));
  endtask

  task automatic wait_drain(input string name, input int budget, input bit with_out);
    int n;
    n = 0;
    while ((exp_ar.size() != 0 || (with_out && exp_out.size() != 0)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_ar.size() != 0 || (with_out && exp_out.size() != 0)) begin
      errors++;
      $display("FAIL %s_timeout: got pending ar=%0d out=%0d required 0", name, exp_ar.size(), exp_out.size());
      exp_ar.delete();
      if (with_out) exp_out.delete();
    end
    repeat (8) @(negedge clk);
    #2 check32({name, "_arvalid_idle"}, 32'(bus.arvalid), 32'd0);
  endtask

  initial begin
    int n, base;
    checks = 0; errors = 0; del_cnt = 0; r_delay = 0; ar_stall = 0; err_addr = 32'h0;
    img[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0};
    img[1] = '{32'h8000_0004, 32'h0010_0093, 1'b0};
    img[2] = '{32'h8000_0008, 32'h0020_8133, 1'b1};
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;

    repeat (2) @(negedge clk);
    #2;
    check32("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check32("rst_rready", 32'(bus.rready), 32'd0);
    check32("rst_araddr", bus.araddr, 32'h0);
    check32("rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Sequential fetch from reset, table-driven; last entry faults so fetch halts.
    for (int i = 0; i < 3; i++) begin
      exp_ar.push_back(img[i].pc);
      exp_out.push_back(img[i]);
      if (img[i].err) err_addr = img[i].pc;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk); #2;
    check32("t1_first_arvalid", 32'(bus.arvalid), 32'd1);
    check32("t1_first_araddr", bus.araddr, 32'h8000_0000);
    @(negedge clk); #2;
    check32("t1_valid_edge2", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #2;
    check32("t1_valid_edge3", 32'(bus.out_valid), 32'd1);
    wait_drain("t1", 100, 1'b1);

    // Backpressure: queue fills with two entries, then fetch resumes at +8.
    @(negedge clk);
    bus.out_ready = 1'b0;
    err_addr = 32'h0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0000;
    push_both(32'h8000_0000, 1'b0);
    push_both(32'h8000_0004, 1'b0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_drain("t2_full", 100, 1'b0);
    check32("t2_full_valid", 32'(bus.out_valid), 32'd1);
    check32("t2_full_pc", bus.out_pc, 32'h8000_0000);
    check32("t2_full_ins", bus.out_ins, 32'h0000_0413);
    @(negedge clk);
    bus.out_ready = 1'b1;
    err_addr = 32'h8000_000C;
    push_both(32'h8000_0008, 1'b0);
    push_both(32'h8000_000C, 1'b1);
    wait_drain("t2", 100, 1'b1);

    // Redirect while the read for +8 is in its data phase with one entry queued.
    @(negedge clk);
    r_delay = 2;
    bus.out_ready = 1'b1;
    err_addr = 32'h0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0000;
    push_both(32'h8000_0000, 1'b0);
    push_both(32'h8000_0004, 1'b0);
    exp_ar.push_back(32'h8000_0008);
    base = del_cnt;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n = 0;
    while (del_cnt == base && n < 100) begin @(negedge clk); n++; end
    bus.out_ready = 1'b0;
    n = 0;
    while (!(bus.rready === 1'b1 && bus.araddr == 32'h8000_0008) && n < 100) begin
      @(negedge clk); n++;
    end
    check32("t3_data_phase", 32'(bus.rready === 1'b1 && bus.araddr == 32'h8000_0008), 32'd1);
    check32("t3_queued_valid", 32'(bus.out_valid), 32'd1);
    check32("t3_queued_pc", bus.out_pc, 32'h8000_0004);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0100;
    err_addr = 32'h8000_0104;
    bus.out_ready = 1'b1;
    #2;
    check32("t3_gated_valid", 32'(bus.out_valid), 32'd0);
    check32("t3_pending_entries", 32'(exp_out.size()), 32'd1);
    exp_out.delete();
    push_both(32'h8000_0100, 1'b0);
    push_both(32'h8000_0104, 1'b1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_drain("t3", 200, 1'b1);
    r_delay = 0;

    // Redirect during a stalled AR: address held, response dropped, next AR is the target.
    @(negedge clk);
    ar_stall = 3;
    err_addr = 32'h8000_0404;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0300;
    exp_ar.push_back(32'h8000_0300);
    push_both(32'h8000_0400, 1'b0);
    push_both(32'h8000_0404, 1'b1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n = 0;
    while (bus.arvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check32("t4_stall_araddr", bus.araddr, 32'h8000_0300);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0400;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #2;
    check32("t4_after_redirect_araddr", bus.araddr, 32'h8000_0300);
    check32("t4_after_redirect_arvalid", 32'(bus.arvalid), 32'd1);
    wait_drain("t4", 100, 1'b1);

    // Fault on +4 halts fetch; a redirect resumes it.
    @(negedge clk);
    err_addr = 32'h8000_0004;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0000;
    push_both(32'h8000_0000, 1'b0);
    push_both(32'h8000_0004, 1'b1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_drain("t5_fault", 100, 1'b1);
    @(negedge clk);
    err_addr = 32'h8000_0208;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0200;
    push_both(32'h8000_0200, 1'b0);
    push_both(32'h8000_0204, 1'b0);
    push_both(32'h8000_0208, 1'b1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_drain("t5", 100, 1'b1);

    // Redirect coincident with a ready head: nothing delivered, next pc is the target.
    @(negedge clk);
    bus.out_ready = 1'b0;
    err_addr = 32'h0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0000;
    push_both(32'h8000_0000, 1'b0);
    push_both(32'h8000_0004, 1'b0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_drain("t6_full", 100, 1'b0);
    check32("t6_full_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h8000_0500;
    err_addr = 32'h8000_0504;
    #2;
    check32("t6_gated_valid", 32'(bus.out_valid), 32'd0);
    check32("t6_pending_entries", 32'(exp_out.size()), 32'd2);
    exp_out.delete();
    push_both(32'h8000_0500, 1'b0);
    push_both(32'h8000_0504, 1'b1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_drain("t6", 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
